// File: rtl/cmul_share_arb_if.sv
// Handshake bundle between the requesters, the shared complex multiplier and the result sinks.
//   s_*       : per-port operand streams (A and B packed {I,Q}, port p at [p*2W +: 2W])
//   mul_in_*  : operand stream towards the shared multiplier
//   mul_out_* : product stream coming back from the multiplier
//   o_*       : per-port result streams (product replicated on every lane)
// Modport master is the arbiter's view; slave is the surrounding environment's view.
interface cmul_share_arb_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PORTS  = 2
);
  logic [NUM_PORTS*2*DATA_WIDTH-1:0] s_adata;
  logic [NUM_PORTS*2*DATA_WIDTH-1:0] s_bdata;
  logic [NUM_PORTS-1:0]              s_tlast;
  logic [NUM_PORTS-1:0]              s_tvalid;
  logic [NUM_PORTS-1:0]              s_tready;
  logic [2*DATA_WIDTH-1:0]           mul_adata;
  logic [2*DATA_WIDTH-1:0]           mul_bdata;
  logic                              mul_in_tlast;
  logic                              mul_in_tvalid;
  logic                              mul_in_tready;
  logic [2*DATA_WIDTH-1:0]           mul_pdata;
  logic                              mul_out_tlast;
  logic                              mul_out_tvalid;
  logic                              mul_out_tready;
  logic [NUM_PORTS*2*DATA_WIDTH-1:0] o_tdata;
  logic [NUM_PORTS-1:0]              o_tlast;
  logic [NUM_PORTS-1:0]              o_tvalid;
  logic [NUM_PORTS-1:0]              o_tready;

  modport master (
    input  s_adata, s_bdata, s_tlast, s_tvalid,
    output s_tready,
    output mul_adata, mul_bdata, mul_in_tlast, mul_in_tvalid,
    input  mul_in_tready,
    input  mul_pdata, mul_out_tlast, mul_out_tvalid,
    output mul_out_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

  modport slave (
    output s_adata, s_bdata, s_tlast, s_tvalid,
    input  s_tready,
    input  mul_adata, mul_bdata, mul_in_tlast, mul_in_tvalid,
    output mul_in_tready,
    output mul_pdata, mul_out_tlast, mul_out_tvalid,
    input  mul_out_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/cmul_share_arb.sv
// Packet-level round-robin arbiter sharing one complex multiplier among NUM_PORTS requesters.
// A grant is held for a whole packet; the granted port index is queued in a tag FIFO so that
// products coming back from the multiplier are steered to the port that issued them.
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : cmul_share_arb_if.master (requester, multiplier and result streams)
//   busy  : high while a packet is locked or results are still outstanding
module cmul_share_arb #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TAG_DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  cmul_share_arb_if.master bus,
  output logic             busy
);
  localparam int unsigned BeatW    = 2 * DATA_WIDTH;
  localparam int unsigned PortW    = $clog2(NUM_PORTS);
  localparam int unsigned TagDepth = 2 ** TAG_DEPTH_LOG2;

  typedef logic [PortW-1:0] port_t;
  typedef enum logic {StIdle, StLocked} state_e;

  state_e state_q, state_d;
  port_t  grant_q, grant_d;
  port_t  last_grant_q, last_grant_d;
  port_t  cand;
  logic   found;

  logic                      tag_push, tag_pop, tag_full, tag_not_empty;
  logic [TAG_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [TAG_DEPTH_LOG2:0]   count_q;
  port_t                     tag_mem [TagDepth];
  port_t                     head;

  assign tag_full      = (count_q == (TAG_DEPTH_LOG2 + 1)'(TagDepth));
  assign tag_not_empty = (count_q != '0);
  assign busy          = (state_q == StLocked) | tag_not_empty;

  // Arbiter: IDLE only picks a port (one bubble per packet), LOCKED forwards combinationally.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    tag_push           = 1'b0;
    found              = 1'b0;
    cand               = '0;
    bus.s_tready       = '0;
    bus.mul_in_tvalid  = 1'b0;
    bus.mul_in_tlast   = 1'b0;
    bus.mul_adata      = '0;
    bus.mul_bdata      = '0;
    unique case (state_q)
      StIdle: begin
        if (!tag_full) begin
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = port_t'((32'(last_grant_q) + 32'd1 + i) % NUM_PORTS);
            if (!found && bus.s_tvalid[cand]) begin
              found    = 1'b1;
              grant_d  = cand;
              state_d  = StLocked;
              tag_push = 1'b1;
            end
          end
        end
      end
      StLocked: begin
        bus.mul_in_tvalid      = bus.s_tvalid[grant_q];
        bus.mul_in_tlast       = bus.s_tlast[grant_q];
        bus.mul_adata          = bus.s_adata[grant_q*BeatW +: BeatW];
        bus.mul_bdata          = bus.s_bdata[grant_q*BeatW +: BeatW];
        bus.s_tready[grant_q]  = bus.mul_in_tready;
        if (bus.s_tvalid[grant_q] && bus.mul_in_tready && bus.s_tlast[grant_q]) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result steering by the oldest outstanding tag; nothing is offered while no tag exists.
  always_comb begin
    head               = tag_mem[rd_ptr_q];
    bus.o_tvalid       = '0;
    bus.o_tlast        = '0;
    bus.o_tvalid[head] = bus.mul_out_tvalid & tag_not_empty;
    bus.o_tlast[head]  = bus.mul_out_tlast;
    bus.mul_out_tready = bus.o_tready[head] & tag_not_empty;
  end

  assign bus.o_tdata = {NUM_PORTS{bus.mul_pdata}};
  assign tag_pop     = bus.mul_out_tvalid & bus.mul_out_tready & bus.mul_out_tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= port_t'(NUM_PORTS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (tag_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while the occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_q] <= grant_d;
  end
endmodule

// File: tb/tb_cmul_share_arb.sv
module tb_cmul_share_arb;
  localparam int NP  = 3;
  localparam int DW  = 16;
  localparam int BW  = 2 * DW;
  localparam int LAT = 6;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          last;
  } beat_t;

  typedef struct {
    int            port;
    logic [BW-1:0] pdata;
    logic          last;
    int            t;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  cmul_share_arb_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  cmul_share_arb #(
    .DATA_WIDTH    (DW),
    .NUM_PORTS     (NP),
    .TAG_DEPTH_LOG2(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: per-port packet queues, round-robin pointer, in-flight results.
  beat_t       bq [NP][$];
  logic        drv_mid [NP];
  res_t        mq[$];
  int          m_last;
  bit          m_mid;
  int          m_cur;
  int unsigned vprob = 100, mrprob = 100, orprob = 100;
  logic [NP-1:0] o_hold = '0;
  bit          force_out = 1'b0;
  bit          rst_req = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          grant_log[$];
  int          res_port[$];
  logic        res_last[$];
  bit          obs_mid;
  int          n_beats;
  logic [NP-1:0] ob_s_tready, ob_o_tvalid;
  logic        ob_min_v, ob_busy, ob_mout_r;

  function automatic logic [NP-1:0] onehot(input int p);
    return NP'(1) << p;
  endfunction

  function automatic int first_set(input logic [NP-1:0] v);
    int r = NP;
    for (int i = NP - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Stand-in multiplier transfer function; any deterministic mix serves.
  function automatic logic [BW-1:0] pf(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return a ^ {b[DW-1:0], b[BW-1:DW]};
  endfunction

  function automatic bit model_idle();
    bit e = (mq.size() == 0);
    for (int p = 0; p < NP; p++) if (bq[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt.a = $urandom;
      bt.b = $urandom;
      bt.last = (i == len - 1);
      bq[p].push_back(bt);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    res_port.delete();
    res_last.delete();
    n_beats = 0;
  endtask

  task automatic step();
    logic [NP-1:0] shs;
    logic          in_hs;
    int            ep, idx, c;
    beat_t         bt;
    res_t          r, h;
    @(negedge clk);
    reset = rst_req;
    for (int p = 0; p < NP; p++) begin
      if (bq[p].size() > 0 && (!drv_mid[p] || $urandom_range(0, 99) < vprob)) begin
        bt = bq[p][0];
        bus.s_tvalid[p] = 1'b1;
        bus.s_adata[p*BW +: BW] = bt.a;
        bus.s_bdata[p*BW +: BW] = bt.b;
        bus.s_tlast[p] = bt.last;
      end else begin
        bus.s_tvalid[p] = 1'b0;
        bus.s_adata[p*BW +: BW] = $urandom;
        bus.s_bdata[p*BW +: BW] = $urandom;
        bus.s_tlast[p] = 1'($urandom);
      end
      bus.o_tready[p] = !o_hold[p] && ($urandom_range(0, 99) < orprob);
    end
    bus.mul_in_tready = ($urandom_range(0, 99) < mrprob);
    if (force_out) begin
      bus.mul_out_tvalid = 1'b1;
      bus.mul_out_tlast = 1'b1;
      bus.mul_pdata = $urandom;
    end else if (mq.size() > 0 && mq[0].t + LAT <= cyc) begin
      bus.mul_out_tvalid = 1'b1;
      bus.mul_out_tlast = mq[0].last;
      bus.mul_pdata = mq[0].pdata;
    end else begin
      bus.mul_out_tvalid = 1'b0;
      bus.mul_out_tlast = 1'($urandom);
      bus.mul_pdata = $urandom;
    end
    #1;
    ob_s_tready = bus.s_tready;
    ob_o_tvalid = bus.o_tvalid;
    ob_min_v    = bus.mul_in_tvalid;
    ob_busy     = busy;
    ob_mout_r   = bus.mul_out_tready;
    if (!rst_req) begin
      shs   = bus.s_tvalid & bus.s_tready;
      in_hs = bus.mul_in_tvalid & bus.mul_in_tready;
      if (shs != '0) begin
        idx = first_set(shs);
        if (!obs_mid) grant_log.push_back(idx);
        obs_mid = !bus.s_tlast[idx];
        n_beats++;
      end
      if (in_hs) begin
        ep = -1;
        if (m_mid) ep = m_cur;
        else begin
          for (int i = 1; i <= NP; i++) begin
            c = (m_last + i) % NP;
            if (ep < 0 && bq[c].size() > 0) ep = c;
          end
        end
        chk("in_beat_expected", 64'(ep >= 0), 64'd1);
        if (ep >= 0) begin
          bt = bq[ep].pop_front();
          chk("in_port", shs, onehot(ep));
          chk("in_adata", bus.mul_adata, bt.a);
          chk("in_bdata", bus.mul_bdata, bt.b);
          chk("in_tlast", bus.mul_in_tlast, bt.last);
          r.port  = ep;
          r.pdata = pf(bus.mul_adata, bus.mul_bdata);
          r.last  = bus.mul_in_tlast;
          r.t     = cyc;
          mq.push_back(r);
          drv_mid[ep] = !bt.last;
          m_mid = !bt.last;
          m_cur = ep;
          if (bt.last) m_last = ep;
        end
      end else begin
        chk("no_stray_accept", shs, '0);
      end
      if (force_out) begin
        chk("notag_mout_ready", bus.mul_out_tready, 1'b0);
        chk("notag_o_tvalid", bus.o_tvalid, '0);
      end else if (bus.mul_out_tvalid) begin
        h = mq[0];
        chk("o_tvalid_route", bus.o_tvalid, onehot(h.port));
        chk("mout_ready", bus.mul_out_tready, bus.o_tready[h.port]);
        chk("o_tlast", bus.o_tlast[h.port], h.last);
        for (int p = 0; p < NP; p++) chk("o_tdata_lane", bus.o_tdata[p*BW +: BW], h.pdata);
        if (bus.mul_out_tready) begin
          res_port.push_back(first_set(bus.o_tvalid));
          res_last.push_back(|(bus.o_tlast & bus.o_tvalid));
          void'(mq.pop_front());
        end
      end else begin
        chk("o_tvalid_idle", bus.o_tvalid, '0);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    for (int p = 0; p < NP; p++) begin
      bq[p].delete();
      drv_mid[p] = 1'b0;
    end
    mq.delete();
    m_last = NP - 1;
    m_mid = 1'b0;
    m_cur = 0;
    obs_mid = 1'b0;
    clear_logs();
    step();
    step();
    rst_req = 1'b0;
    step();
  endtask

  task automatic drain(input string tag, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (model_idle() && !ob_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({"drain_", tag}, 64'(done), 64'd1);
  endtask

  initial begin
    bus.s_adata = '0;
    bus.s_bdata = '0;
    bus.s_tlast = '0;
    bus.s_tvalid = '0;
    bus.mul_in_tready = 1'b0;
    bus.mul_pdata = '0;
    bus.mul_out_tlast = 1'b0;
    bus.mul_out_tvalid = 1'b0;
    bus.o_tready = '0;

    // Reset state
    do_reset();
    chk("rst_s_tready", ob_s_tready, '0);
    chk("rst_min_valid", ob_min_v, 1'b0);
    chk("rst_mout_ready", ob_mout_r, 1'b0);
    chk("rst_o_tvalid", ob_o_tvalid, '0);
    chk("rst_busy", ob_busy, 1'b0);

    // Single 4-beat packet on port 0: one bubble, four beats, back to idle.
    add_pkt(0, 4);
    step();
    chk("p4_bubble_min_valid", ob_min_v, 1'b0);
    step();
    chk("p4_min_valid_next", ob_min_v, 1'b1);
    step();
    step();
    step();
    chk("p4_beats", n_beats, 4);
    step();
    chk("p4_idle_s_tready", ob_s_tready, '0);
    chk("p4_grants", grant_log.size(), 1);
    drain("p4", 200);
    chk("p4_results", res_port.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("p4_res_port", (res_port.size() > i) ? res_port[i] : -1, 0);
      chk("p4_res_last", (res_last.size() > i) ? res_last[i] : 1'bx, (i == 3));
    end

    // Ports 0 and 1 continuously offering 2-beat packets: strict alternation.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    drain("alt", 400);
    chk("alt_grants", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("alt_grant_order", (grant_log.size() > i) ? grant_log[i] : -1, i % 2);

    // Port 0 three beats then port 1 two beats through the 6-cycle multiplier.
    do_reset();
    add_pkt(0, 3);
    add_pkt(1, 2);
    drain("lat", 400);
    chk("lat_results", res_port.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("lat_res_port", (res_port.size() > i) ? res_port[i] : -1, (i < 3) ? 0 : 1);
      chk("lat_res_last", (res_last.size() > i) ? res_last[i] : 1'bx, (i == 2 || i == 4));
    end
    chk("lat_busy_after", ob_busy, 1'b0);

    // Tag FIFO of depth 2 full: third packet waits until a result drains.
    do_reset();
    o_hold[0] = 1'b1;
    for (int k = 0; k < 3; k++) add_pkt(0, 1);
    for (int i = 0; i < 40; i++) step();
    chk("full_grants_held", grant_log.size(), 2);
    chk("full_busy", ob_busy, 1'b1);
    chk("full_s_tready", ob_s_tready, '0);
    o_hold[0] = 1'b0;
    for (int i = 0; i < 40 && grant_log.size() < 3; i++) step();
    chk("full_third_granted", grant_log.size(), 3);
    drain("full", 200);

    // Reset in the middle of beat 2 of a 4-beat port 1 packet.
    do_reset();
    add_pkt(1, 4);
    for (int i = 0; i < 20 && n_beats < 1; i++) step();
    chk("mid_first_beat", n_beats, 1);
    do_reset();
    chk("mid_rst_s_tready", ob_s_tready, '0);
    chk("mid_rst_busy", ob_busy, 1'b0);
    add_pkt(1, 2);
    add_pkt(0, 2);
    drain("mid", 300);
    chk("mid_grants", grant_log.size(), 2);
    chk("mid_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("mid_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

    // Product offered with no tag present.
    force_out = 1'b1;
    for (int i = 0; i < 4; i++) step();
    force_out = 1'b0;

    // Randomized traffic on all ports with random backpressure.
    do_reset();
    vprob = 60;
    mrprob = 60;
    orprob = 60;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 8; k++) add_pkt(p, int'($urandom_range(1, 4)));
    drain("rand_a", 3000);
    do_reset();
    vprob = 90;
    mrprob = 30;
    orprob = 45;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 6; k++) add_pkt(p, int'($urandom_range(1, 5)));
    drain("rand_b", 3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cmul_share_arb.md
CMUL_SHARE_ARB -- requirements
Module: cmul_share_arb

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, component width of I and Q.
REQ-002 Parameters SHALL be: NUM_PORTS, default 2, number of requesters; legal range 2..4.
REQ-003 Parameters SHALL be: TAG_DEPTH_LOG2, default 4, log2 of the packet-tag FIFO depth.
REQ-004 Ports, in order (clock and reset first):
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- s_adata  in  NUM_PORTS*2*DATA_WIDTH  per-port operand A, {I,Q}; port p at bits [p*2W +: 2W].
- s_bdata  in  NUM_PORTS*2*DATA_WIDTH  per-port operand B, same packing.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- s_tvalid  in  NUM_PORTS  per-port input valid.
- s_tready  out  NUM_PORTS  per-port input ready.
- mul_adata  out  2*DATA_WIDTH  operand A to the shared multiplier.
- mul_bdata  out  2*DATA_WIDTH  operand B to the shared multiplier.
- mul_in_tlast  out  1  last flag to the shared multiplier.
- mul_in_tvalid  out  1  valid to the shared multiplier.
- mul_in_tready  in  1  ready from the shared multiplier.
- mul_pdata  in  2*DATA_WIDTH  product from the multiplier.
- mul_out_tlast  in  1  product last flag.
- mul_out_tvalid  in  1  product valid.
- mul_out_tready  out  1  product ready.
- o_tdata  out  NUM_PORTS*2*DATA_WIDTH  per-port result; mul_pdata replicated to every lane.
- o_tlast  out  NUM_PORTS  per-port result last.
- o_tvalid  out  NUM_PORTS  per-port result valid.
- o_tready  in  NUM_PORTS  per-port result ready.
- busy  out  1  high while LOCKED or while the tag FIFO is non-empty.

Function
REQ-005 Arbiter FSM SHALL have exactly two states, IDLE and LOCKED.
REQ-006 In IDLE, grants SHALL be round-robin, starting at port (last_grant+1) mod NUM_PORTS.
REQ-007 In IDLE, the first port with s_tvalid high SHALL be registered as grant, and the FSM SHALL enter LOCKED the next cycle; IDLE accepts no beats (one bubble per packet).
REQ-008 IDLE SHALL NOT grant while the tag FIFO is full.
REQ-009 On each IDLE->LOCKED transition the granted port index SHALL be pushed into the tag FIFO.
REQ-010 In LOCKED, the input path SHALL be combinational:
- mul_in_tvalid = s_tvalid[grant].
- mul_adata, mul_bdata and mul_in_tlast come from the grant port.
- s_tready[grant] = mul_in_tready.
- all other s_tready bits = 0.
REQ-011 A LOCKED beat with s_tlast high and a completed handshake SHALL return the FSM to IDLE and update last_grant to grant.
REQ-012 A grant SHALL never change mid-packet, regardless of other ports' s_tvalid.
REQ-013 Result routing SHALL use the tag FIFO head h, combinationally:
- o_tvalid[h] = mul_out_tvalid & tag_not_empty.
- o_tlast[h] = mul_out_tlast.
- other o_tvalid bits = 0.
- mul_out_tready = o_tready[h] & tag_not_empty.
REQ-014 The tag FIFO SHALL pop on a result handshake with mul_out_tlast high.
REQ-015 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-016 With the tag FIFO empty, mul_out_tready SHALL be 0 and all o_tvalid bits SHALL be 0; results stall.
REQ-017 Data SHALL pass unmodified; the block performs no arithmetic.
REQ-018 The FIFO occupancy counter SHALL be TAG_DEPTH_LOG2+1 bits wide; read/write pointers SHALL wrap modulo 2^TAG_DEPTH_LOG2.
REQ-019 No output SHALL depend combinationally on an input of the same AXI-stream channel's own ready path, except the documented ready pass-through.

Reset
REQ-020 reset high SHALL force on the next clk edge:
- FSM = IDLE.
- last_grant = NUM_PORTS-1, so the first grant is port 0.
- tag FIFO empty.
- s_tready = 0, mul_in_tvalid = 0, mul_out_tready = 0, o_tvalid = 0, busy = 0.
REQ-021 Reset mid-packet SHALL abandon the packet and discard all tags, with no drain.

Verification
REQ-022 Port0 4-beat packet, port1 idle, all readies high -> mul_in_tvalid asserts 1 cycle after port0 s_tvalid rises; 4 beats forwarded; FSM back in IDLE after beat 4.
REQ-023 Ports 0 and 1 both continuously offering 2-beat packets -> grant order 0,1,0,1; no interleaving of beats within a packet.
REQ-024 Model multiplier latency of 6 cycles; port0 packet (3 beats) then port1 packet (2 beats) -> o_tvalid[0] for 3 results ending in o_tlast[0], then o_tvalid[1] for 2 results; tag FIFO empty afterwards.
REQ-025 o_tready[0] held low, TAG_DEPTH_LOG2=1, 3 single-beat packets offered -> 2 grants occur, the third waits (FIFO full); releasing o_tready[0] pops a tag and the third is granted.
REQ-026 Assert reset in the middle of beat 2 of a 4-beat port1 packet -> next cycle all s_tready = 0, busy = 0; a subsequent port1 request is granted with port 0 priority order restored.
REQ-027 mul_out_tvalid high with no tag present (forced) -> mul_out_tready stays 0 and all o_tvalid bits stay 0.
